ps2_key_event_decoder: RTL and testbench



---
 rtl/ps2_key_event_decoder.sv | 175 +++++++++++++++++
 tb/tb_ps2_key_event_decoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-code-set-2 key event decoder.
// Assembles make / E0-extended / F0-break byte sequences into key events,
// filters typematic repeats of the held key, decodes digits and Enter, and
// queues events in a show-ahead FIFO with a valid/ready handshake.
//
// Parser states:
//   state     | meaning
//   ----------+---------------------------------------------
//   S_IDLE    | no partial sequence pending
//   S_EXT     | E0 received, waiting for code or F0
//   S_BRK     | F0 received, waiting for released code
//   S_EXT_BRK | E0 F0 received, waiting for released code
module ps2_key_event_decoder #(
    parameter int TIMEOUT_CYC   = 2500000,
    parameter int REPEAT_FILTER = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CODE_VALID,
    input  logic [7:0] CODE,
    input  logic       CODE_ERR,
    output logic       EV_VALID,
    input  logic       EV_READY,
    output logic [7:0] EV_CODE,
    output logic       EV_EXT,
    output logic       EV_BREAK,
    output logic       EV_IS_DIGIT,
    output logic [3:0] EV_DIGIT,
    output logic       EV_IS_ENTER,
    output logic       OVERFLOW,
    output logic       ERR_SEEN
);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    state_t           state, state_eff, state_nxt;
    logic [CNT_W-1:0] tmo_cnt;
    logic             timeout, is_ctrl;
    logic             emit, emit_ext, emit_brk;
    logic             held_v, held_ext;
    logic [7:0]       held_code;
    logic             held_match, suppress, push;
    logic [4:0]       dig_dec;
    logic [15:0]      push_data, head;
    logic [15:0]      fifo_mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             empty, full, pop, wr_en;

    // Scan-code digit lookup: {is_digit, value}, top row and keypad.
    function automatic logic [4:0] digit_of(input logic [7:0] c);
        case (c)
            8'h45, 8'h70: digit_of = 5'h10;
            8'h16, 8'h69: digit_of = 5'h11;
            8'h1E, 8'h72: digit_of = 5'h12;
            8'h26, 8'h7A: digit_of = 5'h13;
            8'h25, 8'h6B: digit_of = 5'h14;
            8'h2E, 8'h73: digit_of = 5'h15;
            8'h36, 8'h74: digit_of = 5'h16;
            8'h3D, 8'h6C: digit_of = 5'h17;
            8'h3E, 8'h75: digit_of = 5'h18;
            8'h46, 8'h7D: digit_of = 5'h19;
            default:      digit_of = 5'h00;
        endcase
    endfunction

    // Parser next state and event emission; a timeout expiring this cycle
    // makes the current byte be parsed as if from IDLE.
    always_comb begin
        timeout   = (state != S_IDLE) && (tmo_cnt == CNT_LAST);
        state_eff = timeout ? S_IDLE : state;
        state_nxt = state_eff;
        emit      = 1'b0;
        emit_ext  = 1'b0;
        emit_brk  = 1'b0;
        is_ctrl   = CODE inside {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
        if (CODE_VALID) begin
            if (CODE_ERR) begin
                state_nxt = S_IDLE;
            end else begin
                case (state_eff)
                    S_IDLE: begin
                        if (CODE == 8'hE0)      state_nxt = S_EXT;
                        else if (CODE == 8'hF0) state_nxt = S_BRK;
                        else if (!is_ctrl)      emit = 1'b1;
                    end
                    S_EXT: begin
                        if (CODE == 8'hF0)      state_nxt = S_EXT_BRK;
                        else if (CODE == 8'hE0) state_nxt = S_EXT;
                        else begin
                            state_nxt = S_IDLE;
                            emit      = !is_ctrl;
                            emit_ext  = 1'b1;
                        end
                    end
                    S_BRK, S_EXT_BRK: begin
                        state_nxt = S_IDLE;
                        emit      = !(is_ctrl || CODE == 8'hE0 || CODE == 8'hF0);
                        emit_ext  = (state_eff == S_EXT_BRK);
                        emit_brk  = 1'b1;
                    end
                    default: state_nxt = S_IDLE;
                endcase
            end
        end
    end

    // Parser state register and prefix timeout counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            tmo_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (CODE_VALID || state_nxt == S_IDLE) tmo_cnt <= '0;
            else                                   tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    assign held_match = held_v && (held_ext == emit_ext) && (held_code == CODE);
    assign suppress   = (REPEAT_FILTER != 0) && !emit_brk && held_match;
    assign push       = emit && !suppress;
    assign dig_dec    = emit_ext ? 5'h00 : digit_of(CODE);
    assign push_data  = {CODE, emit_ext, emit_brk, dig_dec, CODE == 8'h5A};

    // Held-key tracking for typematic repeat suppression.
    always_ff @(posedge CLK) begin
        if (RST) begin
            held_v    <= 1'b0;
            held_ext  <= 1'b0;
            held_code <= '0;
        end else if (emit) begin
            if (!emit_brk) begin
                held_v    <= 1'b1;
                held_ext  <= emit_ext;
                held_code <= CODE;
            end else if (held_match) begin
                held_v <= 1'b0;
            end
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && EV_READY;
    assign wr_en = push && (!full || pop);

    // FIFO pointers and sticky status flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            OVERFLOW <= 1'b0;
            ERR_SEEN <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop)     OVERFLOW <= 1'b1;
            if (CODE_VALID && CODE_ERR)   ERR_SEEN <= 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge CLK) begin
        if (wr_en) fifo_mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head     = fifo_mem[rd_ptr[AW-1:0]];
    assign EV_VALID = !empty;
    assign {EV_CODE, EV_EXT, EV_BREAK, EV_IS_DIGIT, EV_DIGIT, EV_IS_ENTER} =
        empty ? 16'h0000 : head;
endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Bench for ps2_key_event_decoder: table of single keys plus hand sequences
// for prefixes, repeats, timeout, overflow, errors and reset.
module tb_ps2_key_event_decoder;
    logic       CLK = 1'b0, RST = 1'b1;
    logic       CODE_VALID = 1'b0, CODE_ERR = 1'b0, EV_READY = 1'b1;
    logic [7:0] CODE = 8'h00;
    logic       EV_VALID, EV_EXT, EV_BREAK, EV_IS_DIGIT, EV_IS_ENTER, OVERFLOW, ERR_SEEN;
    logic [7:0] EV_CODE;
    logic [3:0] EV_DIGIT;
    logic       nf_ready = 1'b1;
    logic       nf_valid, nf_ext, nf_brk, nf_isd, nf_ent, nf_ovf, nf_err;
    logic [7:0] nf_code;
    logic [3:0] nf_dig;

    always #5 CLK = ~CLK;

    ps2_key_event_decoder #(.TIMEOUT_CYC(16), .REPEAT_FILTER(1), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .CODE_VALID(CODE_VALID), .CODE(CODE), .CODE_ERR(CODE_ERR),
        .EV_VALID(EV_VALID), .EV_READY(EV_READY), .EV_CODE(EV_CODE), .EV_EXT(EV_EXT),
        .EV_BREAK(EV_BREAK), .EV_IS_DIGIT(EV_IS_DIGIT), .EV_DIGIT(EV_DIGIT),
        .EV_IS_ENTER(EV_IS_ENTER), .OVERFLOW(OVERFLOW), .ERR_SEEN(ERR_SEEN));

    ps2_key_event_decoder #(.TIMEOUT_CYC(16), .REPEAT_FILTER(0), .FIFO_DEPTH(4)) dut_nf (
        .CLK(CLK), .RST(RST), .CODE_VALID(CODE_VALID), .CODE(CODE), .CODE_ERR(CODE_ERR),
        .EV_VALID(nf_valid), .EV_READY(nf_ready), .EV_CODE(nf_code), .EV_EXT(nf_ext),
        .EV_BREAK(nf_brk), .EV_IS_DIGIT(nf_isd), .EV_DIGIT(nf_dig),
        .EV_IS_ENTER(nf_ent), .OVERFLOW(nf_ovf), .ERR_SEEN(nf_err));

    wire [15:0] ev_now = {EV_CODE, EV_EXT, EV_BREAK, EV_IS_DIGIT, EV_DIGIT, EV_IS_ENTER};

    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int nf_makes = 0;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       isd;
        logic [3:0] dig;
        logic       ent;
    } vec_t;
    vec_t tbl[11];

    // Record every accepted head event.
    always @(negedge CLK) if (!RST && EV_VALID && EV_READY) got_q.push_back(ev_now);
    // Count unfiltered makes of key 1E from the non-filtering instance.
    always @(negedge CLK) if (!RST && nf_valid && nf_code == 8'h1E && !nf_ext && !nf_brk) nf_makes++;

    function automatic logic [15:0] ev(input logic [7:0] c, input logic x, input logic b,
                                       input logic d, input logic [3:0] g, input logic e);
        return {c, x, b, d, g, e};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err);
        CODE_VALID = 1'b1;
        CODE       = b;
        CODE_ERR   = err;
        @(posedge CLK);
        #1;
        CODE_VALID = 1'b0;
        CODE_ERR   = 1'b0;
    endtask

    task automatic send_key(input logic [7:0] c, input logic x, input logic b);
        if (x) send_byte(8'hE0, 1'b0);
        if (b) send_byte(8'hF0, 1'b0);
        send_byte(c, 1'b0);
    endtask

    task automatic check_events(input string name);
        int waited = 0;
        while (got_q.size() < exp_q.size() && waited < 64) begin
            @(posedge CLK);
            #1;
            waited++;
        end
        idle(4);
        chk({name, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk(name, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_cleared(input string name);
        chk({name, "_valid"}, EV_VALID, 0);
        chk({name, "_fields"}, ev_now, 0);
        chk({name, "_overflow"}, OVERFLOW, 0);
        chk({name, "_err_seen"}, ERR_SEEN, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nf_before;
        tbl[0]  = '{8'h45, 1'b0, 1'b1, 4'd0, 1'b0};
        tbl[1]  = '{8'h70, 1'b0, 1'b1, 4'd0, 1'b0};
        tbl[2]  = '{8'h69, 1'b0, 1'b1, 4'd1, 1'b0};
        tbl[3]  = '{8'h26, 1'b0, 1'b1, 4'd3, 1'b0};
        tbl[4]  = '{8'h6B, 1'b0, 1'b1, 4'd4, 1'b0};
        tbl[5]  = '{8'h7D, 1'b0, 1'b1, 4'd9, 1'b0};
        tbl[6]  = '{8'h3E, 1'b0, 1'b1, 4'd8, 1'b0};
        tbl[7]  = '{8'h5A, 1'b0, 1'b0, 4'd0, 1'b1};
        tbl[8]  = '{8'h5A, 1'b1, 1'b0, 4'd0, 1'b1};
        tbl[9]  = '{8'h70, 1'b1, 1'b0, 4'd0, 1'b0};
        tbl[10] = '{8'h1C, 1'b0, 1'b0, 4'd0, 1'b0};

        repeat (3) @(posedge CLK);
        #1;
        check_cleared("reset");
        RST = 1'b0;
        idle(2);

        // Make then break of 16, with cycle-exact EV_VALID timing.
        exp_q.push_back(ev(8'h16, 0, 0, 1, 4'd1, 0));
        exp_q.push_back(ev(8'h16, 0, 1, 1, 4'd1, 0));
        send_byte(8'h16, 1'b0);
        chk("t1_make_valid", EV_VALID, 1);
        send_byte(8'hF0, 1'b0);
        chk("t1_popped_gap", EV_VALID, 0);
        send_byte(8'h16, 1'b0);
        chk("t1_break_valid", EV_VALID, 1);
        check_events("t1");

        // Extended vs plain 75.
        exp_q.push_back(ev(8'h75, 1, 0, 0, 4'd0, 0));
        exp_q.push_back(ev(8'h75, 1, 1, 0, 4'd0, 0));
        exp_q.push_back(ev(8'h75, 0, 0, 1, 4'd8, 0));
        exp_q.push_back(ev(8'h75, 0, 1, 1, 4'd8, 0));
        send_key(8'h75, 1, 0);
        send_key(8'h75, 1, 1);
        send_key(8'h75, 0, 0);
        send_key(8'h75, 0, 1);
        check_events("t2");

        // Table of keys, each pressed and released.
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back(ev(tbl[i].code, tbl[i].ext, 0, tbl[i].isd, tbl[i].dig, tbl[i].ent));
            exp_q.push_back(ev(tbl[i].code, tbl[i].ext, 1, tbl[i].isd, tbl[i].dig, tbl[i].ent));
            send_key(tbl[i].code, tbl[i].ext, 0);
            send_key(tbl[i].code, tbl[i].ext, 1);
        end
        check_events("table");

        // Typematic repeat.
        nf_before = nf_makes;
        exp_q.push_back(ev(8'h1E, 0, 0, 1, 4'd2, 0));
        exp_q.push_back(ev(8'h1E, 0, 1, 1, 4'd2, 0));
        repeat (3) send_byte(8'h1E, 1'b0);
        send_key(8'h1E, 0, 1);
        check_events("t3");
        chk("t3_nofilter_makes", nf_makes - nf_before, 3);

        // Control bytes and aborted sequences.
        exp_q.push_back(ev(8'h70, 0, 0, 1, 4'd0, 0));
        exp_q.push_back(ev(8'h12, 1, 0, 0, 4'd0, 0));
        exp_q.push_back(ev(8'h1C, 0, 0, 0, 4'd0, 0));
        send_byte(8'hFA, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'h70, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h1C, 1'b0);
        check_events("t_ctrl");

        // Timeout: long gap, one cycle short, exact expiry.
        exp_q.push_back(ev(8'h5A, 0, 0, 0, 4'd0, 1));
        send_byte(8'hF0, 1'b0);
        idle(20);
        send_byte(8'h5A, 1'b0);
        check_events("t4_long");
        exp_q.push_back(ev(8'h5A, 0, 1, 0, 4'd0, 1));
        send_byte(8'hF0, 1'b0);
        idle(14);
        send_byte(8'h5A, 1'b0);
        check_events("t4_before");
        exp_q.push_back(ev(8'h5A, 0, 0, 0, 4'd0, 1));
        exp_q.push_back(ev(8'h5A, 0, 1, 0, 4'd0, 1));
        send_byte(8'hF0, 1'b0);
        idle(15);
        send_byte(8'h5A, 1'b0);
        send_key(8'h5A, 0, 1);
        check_events("t4_exact");

        // Overflow, then full FIFO with simultaneous push and pop.
        EV_READY = 1'b0;
        exp_q.push_back(ev(8'h15, 0, 0, 0, 4'd0, 0));
        exp_q.push_back(ev(8'h1D, 0, 0, 0, 4'd0, 0));
        exp_q.push_back(ev(8'h24, 0, 0, 0, 4'd0, 0));
        exp_q.push_back(ev(8'h2D, 0, 0, 0, 4'd0, 0));
        send_byte(8'h15, 1'b0);
        send_byte(8'h1D, 1'b0);
        send_byte(8'h24, 1'b0);
        send_byte(8'h2D, 1'b0);
        chk("t5_no_overflow_yet", OVERFLOW, 0);
        send_byte(8'h2C, 1'b0);
        chk("t5_overflow", OVERFLOW, 1);
        idle(2);
        chk("t5_head_held", ev_now, ev(8'h15, 0, 0, 0, 4'd0, 0));
        exp_q.push_back(ev(8'h35, 0, 0, 0, 4'd0, 0));
        EV_READY = 1'b1;
        send_byte(8'h35, 1'b0);
        check_events("t5");
        chk("t5_overflow_sticky", OVERFLOW, 1);

        // Errored byte after E0.
        chk("t6_err_before", ERR_SEEN, 0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h29, 1'b1);
        chk("t6_err_seen", ERR_SEEN, 1);
        exp_q.push_back(ev(8'h29, 0, 0, 0, 4'd0, 0));
        send_byte(8'h29, 1'b0);
        check_events("t6");

        // Reset with a queued event and a pending prefix.
        EV_READY = 1'b0;
        send_byte(8'h16, 1'b0);
        send_byte(8'hE0, 1'b0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check_cleared("t7_reset");
        RST = 1'b0;
        EV_READY = 1'b1;
        got_q.delete();
        exp_q.push_back(ev(8'h16, 0, 0, 1, 4'd1, 0));
        exp_q.push_back(ev(8'h75, 0, 0, 1, 4'd8, 0));
        send_byte(8'h16, 1'b0);
        send_byte(8'h75, 1'b0);
        check_events("t7");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
